// File: rtl/instr_encoder_if.sv
// Request channel and instruction-memory write channel of instr_encoder.
// The master side issues symbolic requests and receives memory writes.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic instruction requests into 32-bit words and writes them to imem.
// Optional macro ENCODER_RANGE_CHECK_EN enables immediate range checking.
module instr_encoder #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              done,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic [2:0]        err,
  output logic [1:0]        state_dbg
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TERM, S_FULL} state_t;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U} fmt_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] PTR_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);
  localparam logic [31:0]       TERM_WORD = 32'h0000_006F;

  state_t            state, nxt;
  fmt_t              fmt;
  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic              legal, imm_bad, accept, term_wr, full_done;
  logic [31:0]       imm, word;
  logic [ADDR_W-1:0] ptr, addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;

  assign imm = bus.in_imm;

  always_comb begin
    fmt   = FMT_R;
    opc   = 7'h33;
    f3    = 3'd0;
    f7    = 7'h00;
    legal = 1'b1;
    case (bus.in_mnem)
      5'd0:  begin f3 = 3'd1; f7 = 7'h20; end
      5'd1:  f3 = 3'd6;
      5'd2:  f3 = 3'd7;
      5'd3:  f3 = 3'd5;
      5'd4:  f3 = 3'd3;
      5'd5:  f3 = 3'd0;
      5'd6:  f3 = 3'd4;
      5'd7:  f3 = 3'd2;
      5'd8:  begin fmt = FMT_I; opc = 7'h13; f3 = 3'd0; end
      5'd9:  begin fmt = FMT_I; opc = 7'h13; f3 = 3'd7; end
      5'd10: begin fmt = FMT_I; opc = 7'h1B; f3 = 3'd6; end
      5'd11: begin fmt = FMT_B; opc = 7'h63; f3 = 3'd0; end
      5'd12: begin fmt = FMT_B; opc = 7'h63; f3 = 3'd1; end
      5'd13: begin fmt = FMT_J; opc = 7'h6F; end
      5'd14: begin fmt = FMT_I; opc = 7'h67; f3 = 3'd0; end
      5'd15: begin fmt = FMT_I; opc = 7'h03; f3 = 3'd0; end
      5'd16: begin fmt = FMT_I; opc = 7'h03; f3 = 3'd2; end
      5'd17: begin fmt = FMT_S; opc = 7'h23; f3 = 3'd0; end
      5'd18: begin fmt = FMT_S; opc = 7'h23; f3 = 3'd1; end
      5'd19: begin fmt = FMT_S; opc = 7'h23; f3 = 3'd2; end
      5'd20: begin fmt = FMT_U; opc = 7'h38; end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    word = '0;
    case (fmt)
      FMT_R: word = {f7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, opc};
      FMT_I: word = {imm[11:0], bus.in_rs1, f3, bus.in_rd, opc};
      FMT_S: word = {imm[11:5], bus.in_rs2, bus.in_rs1, f3, imm[4:0], opc};
      FMT_B: word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3, imm[4:1], imm[11], opc};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, opc};
      FMT_U: word = {imm[31:12], bus.in_rd, opc};
      default: word = '0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // Sign-extension check: all bits above the field's sign bit must match it.
  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: imm_bad = !(&imm[31:11] || ~|imm[31:11]);
      FMT_B:        imm_bad = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
      FMT_J:        imm_bad = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
      FMT_U:        imm_bad = |imm[11:0];
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, start and done, never on in_valid.
  always_comb begin
    bus.in_ready = (state == S_RUN) && !start && !done;
    busy         = (state != S_IDLE);
    state_dbg    = state;
    accept       = bus.in_valid && bus.in_ready;
    term_wr      = (state == S_RUN) && done && !start;
    full_done    = (state == S_FULL) && done && !start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (start) nxt = S_RUN;
    else begin
      case (state)
        S_IDLE: nxt = S_IDLE;
        S_RUN: begin
          if (done)                                          nxt = S_TERM;
          else if (accept && legal && !imm_bad && ptr == LAST_ADDR) nxt = S_FULL;
        end
        S_TERM: nxt = S_IDLE;
        S_FULL: if (done) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // The terminator is registered on the done edge so it is visible during TERM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= BASE_ADDR;
      count   <= '0;
      err     <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (start) begin
        ptr   <= BASE_ADDR;
        count <= '0;
        err   <= '0;
      end else if (term_wr) begin
        we_q    <= 1'b1;
        addr_q  <= ptr;
        wdata_q <= TERM_WORD;
        ptr     <= ptr + PTR_STEP;
        count   <= count + CNT_ONE;
      end else if (full_done) begin
        err[2] <= 1'b1;
      end else if (accept) begin
        if (!legal)       err[0] <= 1'b1;
        else if (imm_bad) err[1] <= 1'b1;
        else begin
          we_q    <= 1'b1;
          addr_q  <= ptr;
          wdata_q <= word;
          ptr     <= ptr + PTR_STEP;
          count   <= count + CNT_ONE;
        end
      end
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan cases plus random
// requests against a behavioural model, with a queue-based write scoreboard.
module tb_instr_encoder;
  localparam int AW = 5;
  localparam int W  = 32 + 2 * AW;
  localparam int M_IDLE = 0, M_RUN = 1, M_TERM = 2, M_FULL = 3;
  localparam int K_R = 0, K_I = 1, K_S = 2, K_B = 3, K_J = 4, K_U = 5;

  logic          clk = 1'b0;
  logic          rst_n, start, done;
  logic [AW-1:0] count;
  logic          busy;
  logic [2:0]    err;
  logic [1:0]    state_dbg;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR('0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .bus(bus),
    .count(count), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           m_state, m_nxt, m_ptr, m_count;
  logic [2:0]   m_err;
  logic [AW-1:0] last_addr;
  logic [31:0]  last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int kind_of(input int m);
    if (m <= 7) return K_R;
    if (m == 11 || m == 12) return K_B;
    if (m == 13) return K_J;
    if (m >= 17 && m <= 19) return K_S;
    if (m == 20) return K_U;
    return K_I;
  endfunction

  function automatic logic [31:0] ref_word(input int m, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    logic [31:0] op, f3, f7;
    f7 = 0; f3 = 0; op = 32'h33;
    case (m)
      0: begin f3 = 1; f7 = 32'h20; end
      1: f3 = 6;
      2: f3 = 7;
      3: f3 = 5;
      4: f3 = 3;
      6: f3 = 4;
      7: f3 = 2;
      8: op = 32'h13;
      9: begin op = 32'h13; f3 = 7; end
      10: begin op = 32'h1B; f3 = 6; end
      11: op = 32'h63;
      12: begin op = 32'h63; f3 = 1; end
      13: op = 32'h6F;
      14: op = 32'h67;
      15: op = 32'h03;
      16: begin op = 32'h03; f3 = 2; end
      17: op = 32'h23;
      18: begin op = 32'h23; f3 = 1; end
      19: begin op = 32'h23; f3 = 2; end
      20: op = 32'h38;
      default: op = 32'h33;
    endcase
    case (kind_of(m))
      K_R: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      K_I: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      K_S: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                  | ((imm & 32'h1F) << 7) | op;
      K_B: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                  | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                  | (((imm >> 11) & 1) << 7) | op;
      K_J: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      default: return (imm & 32'hFFFFF000) | (rd << 7) | op;
    endcase
  endfunction

  function automatic bit range_bad(input int m, input logic [31:0] imm);
`ifdef ENCODER_RANGE_CHECK_EN
    int s;
    s = int'($signed(imm));
    case (kind_of(m))
      K_I, K_S: return (s < -2048) || (s > 2047);
      K_B:      return (s < -4096) || (s > 4095) || imm[0];
      K_J:      return (s < -(1 << 20)) || (s >= (1 << 20)) || imm[0];
      K_U:      return (imm & 32'hFFF) != 0;
      default:  return 1'b0;
    endcase
`else
    return (m < 0) && (imm == 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    m_state = m_nxt;
    chk("busy", 64'(busy), 64'(m_state != M_IDLE));
    chk("err", 64'(err), 64'(m_err));
    chk("count", 64'(count), 64'(m_count));
  endtask

  function automatic void default_nxt();
    m_nxt = (m_state == M_TERM) ? M_IDLE : m_state;
  endfunction

  task automatic push_write(input logic [31:0] data);
    exp_q.push_back({AW'(m_ptr), data, AW'(m_count + 1)});
    m_ptr += 4;
    m_count++;
  endtask

  // lit[32] set means the expected word is the given literal, not the model's.
  task automatic send(input int m, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input logic [32:0] lit);
    bit acc;
    default_nxt();
    bus.in_mnem = 5'(m); bus.in_rd = 5'(rd); bus.in_rs1 = 5'(rs1); bus.in_rs2 = 5'(rs2);
    bus.in_imm = imm; bus.in_valid = 1'b1;
    #1;
    acc = (m_state == M_RUN);
    chk("in_ready", 64'(bus.in_ready), 64'(acc));
    if (acc) begin
      if (m > 20) m_err[0] = 1'b1;
      else if (range_bad(m, imm)) m_err[1] = 1'b1;
      else begin
        push_write(lit[32] ? lit[31:0] : ref_word(m, 32'(rd), 32'(rs1), 32'(rs2), imm));
        if (m_ptr == (1 << AW)) m_nxt = M_FULL;
      end
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_done();
    default_nxt();
    done = 1'b1;
    #1;
    chk("in_ready_done", 64'(bus.in_ready), 64'(0));
    if (m_state == M_RUN) begin
      push_write(32'h0000_006F);
      m_nxt = M_TERM;
    end else if (m_state == M_FULL) begin
      m_err[2] = 1'b1;
      m_nxt = M_IDLE;
    end
    tick();
    done = 1'b0;
  endtask

  task automatic do_start(input bit with_done, input bit with_valid);
    start = 1'b1; done = with_done; bus.in_valid = with_valid;
    bus.in_mnem = 5'($urandom_range(0, 20)); bus.in_imm = 32'($urandom_range(0, 100));
    #1;
    chk("in_ready_start", 64'(bus.in_ready), 64'(0));
    m_ptr = 0; m_count = 0; m_err = '0; m_nxt = M_RUN;
    tick();
    start = 1'b0; done = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      default_nxt();
      tick();
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_we", 64'(bus.imem_we), 64'(0));
    chk("rst_addr", 64'(bus.imem_addr), 64'(0));
    chk("rst_wdata", 64'(bus.imem_wdata), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    m_state = M_IDLE; m_nxt = M_IDLE; m_ptr = 0; m_count = 0; m_err = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_send();
    int m;
    logic [31:0] imm;
    m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(21, 31)) : int'($urandom_range(0, 20));
    case ($urandom_range(0, 3))
      0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: imm = $urandom;
      2: imm = $urandom & 32'hFFFFF000;
      default: imm = 32'($urandom_range(0, 8190)) - 32'd4096;
    endcase
    send(m, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
         int'($urandom_range(0, 31)), imm, '0);
  endtask

  // Monitor: pops the expected write on every strobe, checks hold otherwise.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      last_addr = '0;
      last_data = '0;
    end else if (bus.imem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr %0h data %h, none expected", bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.imem_addr), 64'(e[W-1 -: AW]));
        chk("wr_data", 64'(bus.imem_wdata), 64'(e[AW +: 32]));
        chk("wr_count", 64'(count), 64'(e[AW-1:0]));
        last_addr = e[W-1 -: AW];
        last_data = e[AW +: 32];
      end
    end else begin
      chk("hold_addr", 64'(bus.imem_addr), 64'(last_addr));
      chk("hold_data", 64'(bus.imem_wdata), 64'(last_data));
    end
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; done = 1'b0;
    bus.in_valid = 1'b0; bus.in_mnem = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_imm = '0;
    m_state = M_IDLE; m_nxt = M_IDLE; m_ptr = 0; m_count = 0; m_err = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;

    // Test-plan program: add, addi, beq, sw, terminator.
    do_start(1'b0, 1'b0);
    send(0, 3, 1, 2, 32'd0, {1'b1, 32'h402091B3});
    send(8, 5, 0, 0, 32'hFFFF_FFFF, {1'b1, 32'hFFF00293});
    send(11, 0, 1, 2, 32'd8, {1'b1, 32'h00208463});
    send(19, 0, 1, 2, 32'd4, {1'b1, 32'h0020A223});
    do_done();
    idle(2);

    // Errors: illegal mnemonic, then out-of-range addi.
    do_start(1'b0, 1'b1);
    send(25, 1, 1, 1, 32'd0, '0);
`ifdef ENCODER_RANGE_CHECK_EN
    send(8, 0, 0, 0, 32'd2048, '0);
`else
    send(8, 0, 0, 0, 32'd2048, {1'b1, 32'h80000013});
`endif
    do_done();
    idle(1);

    // Overflow: fill all slots, one refused request, then done.
    do_start(1'b0, 1'b0);
    for (int i = 0; i < (1 << AW) / 4; i++) send(8, i, 0, 0, 32'(i), '0);
    send(0, 1, 2, 3, 32'd0, '0);
    do_done();
    idle(1);

    // Restart in RUN, start overriding done, reset with a pending write.
    do_start(1'b0, 1'b0);
    send(1, 4, 5, 6, 32'd0, '0);
    send(13, 1, 0, 0, 32'd2048, '0);
    do_start(1'b1, 1'b1);
    send(20, 7, 0, 0, 32'hABCDE000, '0);
    send(17, 0, 3, 4, 32'hFFFF_FFF0, '0);
    do_reset();
    idle(1);

    // Randomised traffic.
    do_start(1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) do_start(1'(r == 0), 1'($urandom_range(0, 1)));
      else if (r < 7) do_done();
      else if (r < 12) idle(1);
      else rand_send();
    end
    do_done();
    idle(3);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-loading instruction encoder for the pipelined core: it is the write-side counterpart of the control unit's decode. It accepts symbolic instruction requests (mnemonic, registers, immediate) over a valid/ready handshake and packs them into the core's 32-bit instruction format. It writes the packed words sequentially into instruction memory and closes each program with a self-loop terminator.

## Interface
- `ADDR_W`, 10: instruction-memory byte-address width; capacity is 2^ADDR_W/4 words.
- `BASE_ADDR`, 0: first write address; word aligned.
- `clk` input 1: clock. All logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: pulse; reloads the write pointer to BASE_ADDR, clears `count` and `err`, enters RUN.
- `done` input 1: pulse; ends the program. In RUN, the terminator word is written.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid && in_ready`.
- `in_mnem` input 5: mnemonic code. 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 addi, 9 ori, 10 andi, 11 beq, 12 bne, 13 jal, 14 jalr, 15 lw, 16 lh, 17 sb, 18 sh, 19 sw, 20 lui. Codes 21–31 are illegal.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices. Fields unused by the format are ignored.
- `in_imm` input 32: full signed immediate or offset value.
- `imem_we` output 1: one-cycle write strobe.
- `imem_addr` output ADDR_W: byte address of the write.
- `imem_wdata` output 32: encoded word.
- `count` output ADDR_W: number of words written since `start`, including the terminator.
- `busy` output 1: high when state is not IDLE.
- `err` output 3: sticky error flags. [0] illegal mnemonic, [1] immediate out of range, [2] overflow. Cleared by `start` or reset.

## Operation
- **Encoding.**
  - R-type uses opcode 0x33.
    - add is funct7 0x20, funct3 1.
    - All other R-type ops use funct7 0x00: and f3=7, xor 3, or 5, slt 0, sll 4, srl 2, sub 6.
  - I-type uses opcode 0x13: addi f3=0, ori f3=7.
  - andi uses opcode 0x1B, f3=6.
  - Branches use opcode 0x63: beq f3=0, bne f3=1.
  - jal uses opcode 0x6F; jalr uses opcode 0x67, f3=0.
  - Loads use opcode 0x03: lw f3=0, lh f3=2.
  - Stores use opcode 0x23: sb f3=0, sh f3=1, sw f3=2.
  - lui uses opcode 0x38.
- **Immediate placement** follows standard RISC-V I/S/B/U/J bit scattering.
  - B and J formats drop imm[0].
  - U format takes imm[31:12].
- **State machine: IDLE, RUN, TERM, FULL.**
  - IDLE → RUN on `start`.
  - RUN → TERM on `done`.
  - TERM writes the terminator `jal x0,0` (0x0000006F) at the pointer, then goes to IDLE.
  - RUN → FULL after the word at address 2^ADDR_W−4 is written.
  - FULL → IDLE on `done`. No write occurs, and `err[2]` is set.
  - `start` from any state → RUN; it overrides `done` in the same cycle.
- **`in_ready`** = (state == RUN) && !start && !done.
- **Accepted legal request:** the word is written, the pointer advances by 4, and `count` increments.
- **Accepted illegal or out-of-range request:** it is consumed, no write occurs, the pointer is unchanged, and the corresponding `err` bit is set.
- **TERM reached with a full pointer** cannot occur: FULL intercepts it first.
- **Reset mid-operation:** the pending write is discarded.

## Timing
- **Latency:** the write appears 1 cycle after acceptance; `imem_we` is registered.
- **Throughput:** one request per cycle with no bubbles in RUN.
- **Terminator:** written in the cycle after `done` is sampled.
- **Reset values:**
  - `in_ready` = 0, `imem_we` = 0, `busy` = 0.
  - `imem_addr` = BASE_ADDR, `imem_wdata` = 0.
  - `count` = 0, `err` = 0, state = IDLE.
- **Output hold:** `imem_addr` and `imem_wdata` hold their last values while `imem_we` is 0.

## Configuration
- **`ENCODER_RANGE_CHECK_EN` defined:** immediates are range-checked.
  - I and S: signed 12-bit.
  - B: signed 13-bit and even.
  - J: signed 21-bit and even.
  - U: imm[11:0] must be 0.
  - A violation sets `err[1]` and the request is skipped.
- **Undefined:** immediates are silently truncated to the format and always written; `err[1]` is tied to 0.

## Test plan
- **R-type:** start, then add rd=3 rs1=1 rs2=2 → one cycle later: `imem_we`=1, addr 0x000, data 0x402091B3, `count`=1.
- **Sequence:** three back-to-back requests with `in_valid` held.
  - addi rd=5 rs1=0 imm=−1 → 0xFFF00293 at addr 0x004.
  - beq rs1=1 rs2=2 imm=8 → 0x00208463 at addr 0x008.
  - sw rs1=1 rs2=2 imm=4 → 0x0020A223 at addr 0x00C.
  - Writes occur on consecutive cycles.
- **Termination:** `done` after the sequence → 0x0000006F written at the next address, then `busy` falls and `count`=5.
- **Errors:**
  - `in_mnem`=25 → `err`=3'b001, no write.
  - addi imm=2048 with the macro defined → `err[1]`=1, no write, pointer unchanged.
  - Same request without the macro → 0x80000013 is written.
- **Overflow** with ADDR_W=4: four writes at 0, 4, 8, 12, then `in_ready`=0. `done` → `err[2]`=1, no write, state IDLE.
- **Reset and restart:**
  - `rst_n` asserted mid-RUN → all outputs at reset values immediately.
  - `start` during RUN → next write at BASE_ADDR, `count` restarts at 1.
